// File: rtl/ppg_agc_controller.sv
// PPG front-end auto gain / DC-offset calibration controller (settle, measure min/max, evaluate, lock).
// Optional macro AGC_TRACK_EN: keep measuring while LOCKED and re-enter calibration on drift or clipping.
module ppg_agc_controller #(
    parameter int SETTLE_CYC = 1000,
    parameter int WIN_CYC    = 2000,
    parameter int TARGET_PP  = 96,
    parameter int DC_TOL     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] Vppg,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic       busy,
    output logic       locked,
    output logic       err
);

    localparam int CNT_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_CYC - 1);
    localparam logic [8:0] MID_HI = 9'(128 + DC_TOL);
    localparam logic [8:0] MID_LO = 9'(128 - DC_TOL);
    localparam logic [8:0] PP_TGT = 9'(TARGET_PP);
`ifdef AGC_TRACK_EN
    localparam logic [8:0] TRK_HI = 9'(128 + 2 * DC_TOL);
    localparam logic [8:0] TRK_LO = 9'(128 - 2 * DC_TOL);
`endif

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, LOCKED} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    vmin, vmin_n, vmax, vmax_n;
    logic [7:0]    eval_cnt, eval_n;
    logic [6:0]    dc_n;
    logic [3:0]    gain_n;
    logic          busy_n, locked_n, err_n;
    logic          rst_dly;
    logic          start_ok;
    logic [7:0]    samp_min, samp_max, mid, pp;
    logic          clip, eval_lock, eval_fail;

    // A start on the first edge after reset release is deliberately dropped.
    assign start_ok = start && !rst_dly;

    assign samp_min = (Vppg < vmin) ? Vppg : vmin;
    assign samp_max = (Vppg > vmax) ? Vppg : vmax;
    assign mid      = 8'(({1'b0, vmin} + {1'b0, vmax}) >> 1);
    assign pp       = vmax - vmin;
    assign clip     = (vmax == 8'hFF) || (vmin == 8'h00);

`ifdef AGC_TRACK_EN
    logic [7:0] trk_mid;
    logic       trk_bad;
    assign trk_mid = 8'(({1'b0, samp_min} + {1'b0, samp_max}) >> 1);
    assign trk_bad = (samp_max == 8'hFF) || (samp_min == 8'h00) ||
                     ({1'b0, trk_mid} > TRK_HI) || ({1'b0, trk_mid} < TRK_LO);
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        vmin_n    = vmin;
        vmax_n    = vmax;
        eval_n    = eval_cnt;
        dc_n      = DC_Comp;
        gain_n    = PGA_Gain;
        busy_n    = busy;
        locked_n  = locked;
        err_n     = err;
        eval_lock = 1'b0;
        eval_fail = 1'b0;

        case (state)
            IDLE: begin
                state_n = IDLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = '0;
                    vmin_n  = 8'hFF;
                    vmax_n  = 8'h00;
                    state_n = MEASURE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            MEASURE: begin
                vmin_n = samp_min;
                vmax_n = samp_max;
                if (cnt == WIN_LAST) begin
                    cnt_n   = '0;
                    state_n = EVAL;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EVAL: begin
                state_n = SETTLE;
                eval_n  = eval_cnt + 8'd1;
                // Priority: clipping, then DC centring, then gain; one code moves per pass.
                if (clip) begin
                    if (PGA_Gain != 4'd0)
                        gain_n = PGA_Gain - 4'd1;
                    else if (vmax == 8'hFF) begin
                        if (DC_Comp == 7'd127) eval_fail = 1'b1;
                        else                   dc_n = DC_Comp + 7'd1;
                    end else begin
                        if (DC_Comp == 7'd0) eval_fail = 1'b1;
                        else                 dc_n = DC_Comp - 7'd1;
                    end
                end else if ({1'b0, mid} > MID_HI) begin
                    if (DC_Comp == 7'd127) eval_fail = 1'b1;
                    else                   dc_n = DC_Comp + 7'd1;
                end else if ({1'b0, mid} < MID_LO) begin
                    if (DC_Comp == 7'd0) eval_fail = 1'b1;
                    else                 dc_n = DC_Comp - 7'd1;
                end else if (({1'b0, pp} < PP_TGT) && (PGA_Gain != 4'd15)) begin
                    gain_n = PGA_Gain + 4'd1;
                end else begin
                    eval_lock = 1'b1;
                end

                if (eval_lock) begin
                    state_n  = LOCKED;
                    locked_n = 1'b1;
                    busy_n   = 1'b0;
                    cnt_n    = '0;
                    vmin_n   = 8'hFF;
                    vmax_n   = 8'h00;
                end else if (eval_fail || (eval_cnt == 8'hFF)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    dc_n    = DC_Comp;
                    gain_n  = PGA_Gain;
                end
            end
            LOCKED: begin
                state_n = LOCKED;
`ifdef AGC_TRACK_EN
                vmin_n = samp_min;
                vmax_n = samp_max;
                if (cnt == WIN_LAST) begin
                    cnt_n = '0;
                    if (trk_bad) begin
                        state_n  = EVAL;
                        locked_n = 1'b0;
                        busy_n   = 1'b1;
                        eval_n   = 8'd0;
                    end else begin
                        vmin_n = 8'hFF;
                        vmax_n = 8'h00;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        if (start_ok && ((state == IDLE) || (state == LOCKED))) begin
            state_n  = SETTLE;
            cnt_n    = '0;
            eval_n   = 8'd0;
            dc_n     = 7'd0;
            gain_n   = 4'd0;
            busy_n   = 1'b1;
            locked_n = 1'b0;
            err_n    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            vmin     <= 8'hFF;
            vmax     <= 8'h00;
            eval_cnt <= 8'd0;
            DC_Comp  <= 7'd0;
            PGA_Gain <= 4'd0;
            busy     <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            rst_dly  <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            vmin     <= vmin_n;
            vmax     <= vmax_n;
            eval_cnt <= eval_n;
            DC_Comp  <= dc_n;
            PGA_Gain <= gain_n;
            busy     <= busy_n;
            locked   <= locked_n;
            err      <= err_n;
            rst_dly  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppg_agc_controller.sv
// Self-checking bench for ppg_agc_controller: cycle-accurate vector table plus plant-model and corner sequences.
module tb_ppg_agc_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] Vppg = 8'd128;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic       busy, locked, err;

    int total = 0;
    int bad = 0;
    bit plant_on = 1'b0;
    bit phase = 1'b0;

    typedef struct {
        logic        st;
        logic [7:0]  v;
        logic [13:0] exp;
    } vec_t;

    vec_t       vecs [16];
    logic [7:0] sine [8] = '{8'd128, 8'd163, 8'd178, 8'd163, 8'd128, 8'd93, 8'd78, 8'd93};

    ppg_agc_controller #(
        .SETTLE_CYC(4),
        .WIN_CYC(8),
        .TARGET_PP(64),
        .DC_TOL(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .Vppg(Vppg),
        .DC_Comp(DC_Comp),
        .PGA_Gain(PGA_Gain),
        .busy(busy),
        .locked(locked),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic b, input logic l, input logic e,
                                       input logic [6:0] dc, input logic [3:0] g);
        return {b, l, e, dc, g};
    endfunction

    function automatic int outs();
        return int'({busy, locked, err, DC_Comp, PGA_Gain});
    endfunction

    // Front-end model: baseline 200-4*DC_Comp, swing 10*(PGA_Gain+1), alternating extremes.
    task automatic step();
        int base, half, v;
        @(posedge clk);
        #1;
        if (plant_on) begin
            phase = ~phase;
            base  = 200 - 4 * int'(DC_Comp);
            half  = 5 * (int'(PGA_Gain) + 1);
            v     = phase ? base + half : base - half;
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            Vppg = 8'(v);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] v);
        start = s;
        Vppg  = v;
        step();
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int gain_max;
        int dc_at;
        bit seen;

        // Row i: inputs before edge i, outputs expected after edge i.
        for (int i = 0; i < 16; i++) vecs[i] = '{st: 1'b0, v: 8'd128, exp: pk(1'b1, 1'b0, 1'b0, 7'd0, 4'd0)};
        vecs[0].st = 1'b1;
        vecs[3].st = 1'b1;
        for (int i = 5; i <= 12; i++) vecs[i].v = sine[i-5];
        vecs[13].exp = pk(1'b0, 1'b1, 1'b0, 7'd0, 4'd0);
        vecs[14].exp = pk(1'b0, 1'b1, 1'b0, 7'd0, 4'd0);
        vecs[15].st  = 1'b1;

        $display("[TB] reset and release");
        applyStimulus(1'b0, 8'd128);
        applyStimulus(1'b0, 8'd128);
        checkOutput("reset_state", outs(), int'(pk(1'b0, 1'b0, 1'b0, 7'd0, 4'd0)));
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'd128);
        checkOutput("release_edge_start_ignored", outs(), int'(pk(1'b0, 1'b0, 1'b0, 7'd0, 4'd0)));
        applyStimulus(1'b0, 8'd128);

        $display("[TB] vector table: centred sine locks in 14 cycles");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].st, vecs[i].v);
            checkOutput($sformatf("vec%0d", i), outs(), int'(vecs[i].exp));
        end

        $display("[TB] plant model convergence");
        resetDut();
        plant_on = 1'b1;
        applyStimulus(1'b1, 8'd128);
        start = 1'b0;
        seen  = 1'b0;
        dc_at = -1;
        for (n = 0; n < 3000 && !locked && !err; n++) begin
            step();
            if (!seen && PGA_Gain != 4'd0) begin
                seen  = 1'b1;
                dc_at = int'(DC_Comp);
            end
        end
        checkOutput("plant_dc_before_gain", dc_at, 16);
        checkOutput("plant_final", outs(), int'(pk(1'b0, 1'b1, 1'b0, 7'd16, 4'd6)));

        plant_on = 1'b0;
        Vppg = 8'd0;
`ifdef AGC_TRACK_EN
        $display("[TB] tracking: zero window forces recalibration");
        for (n = 0; n < 30 && locked; n++) step();
        checkOutput("track_unlock", outs(), int'(pk(1'b1, 1'b0, 1'b0, 7'd16, 4'd6)));
        step();
        checkOutput("track_gain_dec", int'(PGA_Gain), 5);
        checkOutput("track_dc_hold", int'(DC_Comp), 16);
`else
        $display("[TB] locked hold ignores Vppg");
        for (n = 0; n < 30; n++) step();
        checkOutput("hold_locked", outs(), int'(pk(1'b0, 1'b1, 1'b0, 7'd16, 4'd6)));
`endif

        $display("[TB] Vppg stuck at 255");
        resetDut();
        applyStimulus(1'b1, 8'd255);
        start = 1'b0;
        gain_max = 0;
        for (n = 0; n < 2000 && !err; ) begin
            step();
            n++;
            if (int'(PGA_Gain) > gain_max) gain_max = int'(PGA_Gain);
        end
        checkOutput("stuck_final", outs(), int'(pk(1'b0, 1'b0, 1'b1, 7'd127, 4'd0)));
        checkOutput("stuck_gain_max", gain_max, 0);
        checkOutput("stuck_cycles", n, 1664);
        applyStimulus(1'b1, 8'd128);
        start = 1'b0;
        checkOutput("restart_clears_err", outs(), int'(pk(1'b1, 1'b0, 1'b0, 7'd0, 4'd0)));

        $display("[TB] reset during MEASURE then clean restart");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'd128);
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'd128);
        checkOutput("reset_mid_measure", outs(), int'(pk(1'b0, 1'b0, 1'b0, 7'd0, 4'd0)));
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'd128);
        applyStimulus(1'b1, 8'd128);
        for (int i = 1; i <= 13; i++)
            applyStimulus(1'b0, (i >= 5 && i <= 12) ? sine[i-5] : 8'd128);
        checkOutput("restart_lock", outs(), int'(pk(1'b0, 1'b1, 1'b0, 7'd0, 4'd0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
